stage4: RTL and testbench

STAGE4 -- requirements
Module: stage4

---
 rtl/stage4_pkg.sv | 5 +
 rtl/stage4_wb_register.sv | 16 +
 rtl/stage4.sv | 24 ++
 tb/tb_stage4.sv | 87 ++++++++
 4 files changed

// File: rtl/stage4_pkg.sv
// stage4_pkg: shared datapath width and write-back source encoding.
package stage4_pkg;
  localparam int DATA_W = 16;
  typedef enum logic {SEL_MEM = 1'b0, SEL_MDR = 1'b1} sel_e;
endpackage

// File: rtl/stage4_wb_register.sv
// wb_register: enabled data register with asynchronous active-low clear.
module wb_register #(
  parameter int WIDTH = stage4_pkg::DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_q <= '0;
    else if (en_i) q_q <= d_i;
  assign q_o = q_q;
endmodule

// File: rtl/stage4.sv
// stage4: write-back stage selecting mdrOut or memOut into a held register.
module stage4
  import stage4_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             regop,
  input  logic             regw,
  input  logic [WIDTH-1:0] mdrOut,
  input  logic [WIDTH-1:0] memOut,
  output logic [WIDTH-1:0] reggieOut
);
  logic [WIDTH-1:0] wb_d;
  assign wb_d = (sel_e'(regop) == SEL_MDR) ? mdrOut : memOut;
  wb_register #(.WIDTH(WIDTH)) u_wb_reg (
    .clk_i (CLK),
    .rst_ni(reset),
    .en_i  (regw),
    .d_i   (wb_d),
    .q_o   (reggieOut)
  );
endmodule

// File: tb/tb_stage4.sv
// tb_stage4: scoreboard bench for stage4 with directed and random write-back traffic.
module tb_stage4;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        regop = 1'b0;
  logic        regw = 1'b0;
  logic [15:0] mdrOut = '0;
  logic [15:0] memOut = '0;
  logic [15:0] reggieOut;
  int checks = 0;
  int failures = 0;
  logic [15:0] model = '0;
  typedef struct {
    logic [15:0] val;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  stage4 dut (
    .CLK      (CLK),
    .reset    (reset),
    .regop    (regop),
    .regw     (regw),
    .mdrOut   (mdrOut),
    .memOut   (memOut),
    .reggieOut(reggieOut)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs mid-period and queue the value expected after the next edge.
  task automatic cyc(input string name, input logic rst, input logic op, input logic w,
                     input logic [15:0] mdr, input logic [15:0] mem);
    exp_t e;
    @(negedge CLK);
    reset = rst; regop = op; regw = w; mdrOut = mdr; memOut = mem;
    if (!rst) model = 16'h0000;
    else if (w) model = op ? mdr : mem;
    e.val = model;
    e.name = name;
    exp_q.push_back(e);
    if (!rst) begin
      #1;
      chk({name, "_async"}, reggieOut, 16'h0000);
    end
  endtask

  always begin
    exp_t e;
    @(posedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.name, reggieOut, e.val);
    end
  end

  initial begin
    #2 reset = 1'b0;
    #1 chk("init_async_rst", reggieOut, 16'h0000);
    cyc("rst_regw1", 1'b0, 1'b1, 1'b1, 16'hABCD, 16'h1234);
    cyc("wr_mdr", 1'b1, 1'b1, 1'b1, 16'hABCD, 16'h1234);
    cyc("wr_mem", 1'b1, 1'b0, 1'b1, 16'hABCD, 16'h1234);
    for (int i = 0; i < 3; i++)
      cyc("hold", 1'b1, i[0], 1'b0, 16'hFFFF, 16'h0000);
    for (int i = 0; i < 6; i++)
      cyc("alt", 1'b1, ~i[0], 1'b1, 16'h5A5A, 16'hA5A5);
    cyc("mid_rst", 1'b0, 1'b1, 1'b0, 16'h5A5A, 16'hA5A5);
    cyc("post_rst_wr", 1'b1, 1'b1, 1'b1, 16'h5A5A, 16'hA5A5);
    for (int i = 0; i < 300; i++)
      cyc("rand", ($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
          16'($urandom), 16'($urandom));
    repeat (3) @(posedge CLK);
    #2;
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
